// File: rtl/dmem_store_buffer.sv
// Data-side store buffer: posts stores into an in-order FIFO drained in the background,
// and serialises loads behind the drain. Optional store-to-load forwarding under DMEM_FWD_EN.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_write_i,
  input  logic          mem_read_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [3:0]    be_i,
  output logic [DW-1:0] rdata_o,
  output logic          stall_o,
  output logic          bus_req_o,
  output logic          bus_we_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [DW-1:0] bus_wdata_o,
  output logic [3:0]    bus_be_o,
  input  logic          bus_gnt_i,
  input  logic          bus_rvalid_i,
  input  logic [DW-1:0] bus_rdata_i
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, RD_DONE} state_t;
  state_t state, state_nxt;

  logic [AW-1:0] q_addr [DEPTH];
  logic [DW-1:0] q_data [DEPTH];
  logic [3:0]    q_be   [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [DW-1:0] rdata_q;
  logic          full, empty, push, pop;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = mem_write_i & ~full;
  assign pop   = (state == IDLE) & ~empty & bus_gnt_i;

`ifdef DMEM_FWD_EN
  logic          fwd_match;
  logic [3:0]    fwd_be;
  logic [PW-1:0] idx;

  // Scan oldest to youngest so the last match left standing is the youngest store.
  always_comb begin
    fwd_match = 1'b0;
    fwd_be    = '0;
    fwd_data  = '0;
    idx       = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((i < int'(count)) && (q_addr[idx][AW-1:2] == addr_i[AW-1:2])) begin
        fwd_match = 1'b1;
        fwd_be    = q_be[idx];
        fwd_data  = q_data[idx];
      end
    end
    fwd_hit = (state == IDLE) & mem_read_i & fwd_match & ((fwd_be & be_i) == be_i);
  end
`else
  logic unused_be;
  assign unused_be = ^be_i;
  assign fwd_hit   = 1'b0;
  assign fwd_data  = '0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= addr_i;
      q_data[wr_ptr] <= wdata_i;
      q_be[wr_ptr]   <= be_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rdata_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      // Forwarded data is latched too so rdata_o holds it after the load retires.
      if (state == RD_WAIT && bus_rvalid_i) rdata_q <= bus_rdata_i;
      else if (fwd_hit)                     rdata_q <= fwd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_read_i && !fwd_hit && empty) state_nxt = RD_REQ;
      RD_REQ:  if (bus_gnt_i)    state_nxt = RD_WAIT;
      RD_WAIT: if (bus_rvalid_i) state_nxt = RD_DONE;
      RD_DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = q_addr[rd_ptr];
    bus_wdata_o = q_data[rd_ptr];
    bus_be_o    = q_be[rd_ptr];
    stall_o     = full;
    case (state)
      IDLE: begin
        bus_req_o = ~empty;
        bus_we_o  = ~empty;
        if (mem_read_i && !fwd_hit) stall_o = 1'b1;
      end
      RD_REQ: begin
        bus_req_o   = 1'b1;
        bus_addr_o  = {addr_i[AW-1:2], 2'b00};
        bus_wdata_o = '0;
        bus_be_o    = 4'hF;
        stall_o     = 1'b1;
      end
      RD_WAIT: stall_o = 1'b1;
      default: ;
    endcase
  end

  assign rdata_o = fwd_hit ? fwd_data : rdata_q;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Scoreboard bench for dmem_store_buffer: expected bus transfers are queued as stores/loads
// are issued and compared in order by a bus monitor; load data and stall timing checked inline.
module tb_dmem_store_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_write_i = 1'b0, mem_read_i = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic [3:0]  be_i = '0;
  logic [31:0] rdata_o;
  logic        stall_o, bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i = 1'b0, bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;

  logic        rv_en = 1'b1, force_rv = 1'b0, rd_hs = 1'b0;
  logic [31:0] rd_data = '0;
  int          n_chk = 0, n_err = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } bus_t;
  bus_t exp_q[$];

  dmem_store_buffer dut (
    .clk(clk), .rst(rst),
    .mem_write_i(mem_write_i), .mem_read_i(mem_read_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i),
    .rdata_o(rdata_o), .stall_o(stall_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus monitor: every accepted transfer must match the head of the expected queue.
  always @(negedge clk) begin
    bus_t e;
    rd_hs = 1'b0;
    if (!rst && bus_req_o === 1'b1 && bus_gnt_i === 1'b1) begin
      if (exp_q.size() == 0) chk("bus_unexpected", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        chk("bus_we", {31'b0, bus_we_o}, {31'b0, e.we});
        chk("bus_addr", bus_addr_o, e.addr);
        chk("bus_be", {28'b0, bus_be_o}, {28'b0, e.be});
        if (e.we) chk("bus_wdata", bus_wdata_o, e.data);
      end
      if (!bus_we_o) rd_hs = 1'b1;
    end
  end

  // Read responder: rvalid one cycle after the read grant.
  always begin
    @(posedge clk);
    #1;
    bus_rvalid_i = (rd_hs & rv_en) | force_rv;
    bus_rdata_i  = rd_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    bus_t e;
    int n = 0;
    mem_write_i = 1'b1; addr_i = a; wdata_i = d; be_i = b;
    #1;
    while (stall_o && n < 50) begin tick(); #1; n++; end
    if (n >= 50) chk("store_timeout", 32'(n), 32'd0);
    e.we = 1'b1; e.addr = a; e.data = d; e.be = b;
    exp_q.push_back(e);
    tick();
    mem_write_i = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] exp_d, input int exp_stalls, input bit via_bus);
    bus_t e;
    int n = 0;
    mem_read_i = 1'b1; addr_i = a; be_i = b;
    if (via_bus) begin
      e.we = 1'b0; e.addr = {a[31:2], 2'b00}; e.data = '0; e.be = 4'hF;
      exp_q.push_back(e);
    end
    #1;
    while (stall_o && n < 50) begin bus_gnt_i = 1'b1; tick(); #1; n++; end
    chk({tag, "_data"}, rdata_o, exp_d);
    if (exp_stalls >= 0) chk({tag, "_stalls"}, 32'(n), 32'(exp_stalls));
    tick();
    mem_read_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin tick(); n++; end
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_t e;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    chk("rst_req", {31'b0, bus_req_o}, 32'd0);
    chk("rst_count", 32'(dut.count), 32'd0);
    tick();

    // Posted stores with the bus blocked, then in-order drain.
    bus_gnt_i = 1'b0;
    do_store(32'h100, 32'hA, 4'hF);
    do_store(32'h104, 32'hB, 4'hF);
    do_store(32'h108, 32'hC, 4'hF);
    #1;
    chk("t1_count", 32'(dut.count), 32'd3);
    chk("t1_stall", {31'b0, stall_o}, 32'd0);
    chk("t1_req", {31'b0, bus_req_o}, 32'd1);
    chk("t1_head", bus_addr_o, 32'h100);
    bus_gnt_i = 1'b1;
    wait_drain("t1");
    bus_gnt_i = 1'b0;
    tick();

    // Full FIFO stalls the fifth store until a single grant frees an entry.
    for (int i = 0; i < 4; i++) do_store(32'h300 + 32'(4 * i), 32'h50 + 32'(i), 4'(i + 1));
    mem_write_i = 1'b1; addr_i = 32'h310; wdata_i = 32'h55; be_i = 4'hC;
    #1;
    chk("t2_full_stall", {31'b0, stall_o}, 32'd1);
    bus_gnt_i = 1'b1;
    tick();
    bus_gnt_i = 1'b0;
    #1;
    chk("t2_unstall", {31'b0, stall_o}, 32'd0);
    chk("t2_count_pop", 32'(dut.count), 32'd3);
    e.we = 1'b1; e.addr = 32'h310; e.data = 32'h55; e.be = 4'hC;
    exp_q.push_back(e);
    tick();
    mem_write_i = 1'b0;
    #1;
    chk("t2_count_push", 32'(dut.count), 32'd4);
    bus_gnt_i = 1'b1;
    wait_drain("t2");
    tick();

    // Load with empty FIFO: 3 stall cycles then data.
    rd_data = 32'hDEADBEEF;
    do_load("t3", 32'h200, 4'hF, 32'hDEADBEEF, 3, 1'b1);
    #1;
    chk("t3_hold", rdata_o, 32'hDEADBEEF);
    tick();

    // Store then load to the same word.
    bus_gnt_i = 1'b0;
    do_store(32'h100, 32'h11223344, 4'hF);
`ifdef DMEM_FWD_EN
    do_load("t4_fwd", 32'h100, 4'hF, 32'h11223344, 0, 1'b0);
    bus_gnt_i = 1'b1;
    wait_drain("t4");
`else
    rd_data = 32'h55667788;
    do_load("t4", 32'h100, 4'hF, 32'h55667788, -1, 1'b1);
    wait_drain("t4");
`endif
    tick();

    // Partial byte cover must take the bus path.
    bus_gnt_i = 1'b0;
    do_store(32'h100, 32'hAA, 4'b0001);
    rd_data = 32'hCAFEF00D;
    do_load("t5", 32'h100, 4'hF, 32'hCAFEF00D, -1, 1'b1);
    wait_drain("t5");
    tick();

    // Reset while waiting for read data; a late rvalid must be ignored.
    rv_en = 1'b0;
    bus_gnt_i = 1'b1;
    mem_read_i = 1'b1; addr_i = 32'h400; be_i = 4'hF;
    e.we = 1'b0; e.addr = 32'h400; e.data = '0; e.be = 4'hF;
    exp_q.push_back(e);
    tick(); tick();
    #1;
    chk("t6_wait_stall", {31'b0, stall_o}, 32'd1);
    chk("t6_wait_req", {31'b0, bus_req_o}, 32'd0);
    rst = 1'b1;
    mem_read_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("t6_rdata", rdata_o, 32'h0);
    chk("t6_stall", {31'b0, stall_o}, 32'd0);
    chk("t6_count", 32'(dut.count), 32'd0);
    chk("t6_req", {31'b0, bus_req_o}, 32'd0);
    rd_data = 32'h12345678;
    force_rv = 1'b1;
    tick(); tick();
    force_rv = 1'b0;
    tick();
    #1;
    chk("t6_late_rvalid", rdata_o, 32'h0);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
